// File: rtl/par_port_pkg.sv
// par_port_pkg: shared FSM state, ACK counter width and reset constants for the parallel port receiver
package par_port_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, ACK, WAIT_HI} rx_state_e;
  localparam int ACK_CW = 4;
  localparam logic SYNC_RST = 1'b0;
  localparam logic NACK_RST = 1'b1;
  localparam logic IRQ_RST = 1'b1;
  localparam logic [7:0] DATA_RST = 8'h00;
endpackage

// File: rtl/par_rx_fifo.sv
// par_rx_fifo: synchronous byte FIFO with registered head output and wrap-bit full/empty
module par_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  import par_port_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, rp_n;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] dout_q, dout_d;
  logic do_wr, do_rd;
  // Pointer compare, pop/push qualification and next head value
  always_comb begin
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_rd = rd & ~empty;
    do_wr = wr & (~full | do_rd);
    rp_n = rp_q + 1'b1;
    wp_d = do_wr ? wp_q + 1'b1 : wp_q;
    rp_d = do_rd ? rp_n : rp_q;
    dout_d = do_rd ? ((rp_n == wp_q) ? (do_wr ? din : dout_q) : mem_q[rp_n[AW-1:0]])
                   : ((empty & do_wr) ? din : dout_q);
  end
  // Storage array, not reset: contents are only visible through dout_q
  always_ff @(posedge clk) if (do_wr) mem_q[wp_d[AW-1:0] - 1'b1] <= din;
  // Pointers and registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      dout_q <= DATA_RST;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
endmodule

// File: rtl/par_port_rx.sv
// par_port_rx: strobed parallel port receiver with BUSY/nACK handshake and FIFO; PAR_RX_IRQ_EN builds nIRQ
module par_port_rx #(
  parameter int DEPTH = 4,
  parameter int ACK_CYCLES = 3
) (
  input  logic       E,
  input  logic       RES,
  input  logic       nSTB,
  input  logic [7:0] PD,
  output logic       BUSY,
  output logic       nACK,
  input  logic       RD,
  output logic [7:0] RD_DATA,
  output logic       EMPTY,
  output logic       FULL,
  output logic       OVR,
  input  logic       CLR_OVR,
  input  logic       IE,
  output logic       nIRQ
);
  import par_port_pkg::*;
  logic stb_s1_q, stb_s2_q, stb_prev_q, stb_ev;
  logic [7:0] pd_s1_q, pd_s2_q, hold_q, hold_d;
  rx_state_e state_q, state_d;
  logic [ACK_CW-1:0] cnt_q, cnt_d;
  logic nack_q, nack_d, ovr_q, ovr_d, wr_en;
  // Synchronisers and edge register; reset low so a strobe held across reset is not an event
  always_ff @(posedge E or posedge RES) begin
    if (RES) begin
      stb_s1_q <= SYNC_RST;
      stb_s2_q <= SYNC_RST;
      stb_prev_q <= SYNC_RST;
      pd_s1_q <= DATA_RST;
      pd_s2_q <= DATA_RST;
    end else begin
      stb_s1_q <= nSTB;
      stb_s2_q <= stb_s1_q;
      stb_prev_q <= stb_s2_q;
      pd_s1_q <= PD;
      pd_s2_q <= pd_s1_q;
    end
  end
  // Handshake FSM next state, hold register, ACK counter and overrun flag
  always_comb begin
    stb_ev = stb_prev_q & ~stb_s2_q;
    state_d = state_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    case (state_q)
      IDLE: if (stb_ev) begin
        hold_d = pd_s2_q;
        state_d = HOLD;
      end
      HOLD: if (~FULL | RD) begin
        wr_en = 1'b1;
        cnt_d = ACK_CW'(ACK_CYCLES - 1);
        state_d = ACK;
      end
      ACK: if (cnt_q == '0) state_d = WAIT_HI;
           else cnt_d = cnt_q - 1'b1;
      WAIT_HI: if (stb_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    nack_d = state_q != ACK;
    ovr_d = (stb_ev & (state_q != IDLE)) | (ovr_q & ~CLR_OVR);
  end
  // Control state registers
  always_ff @(posedge E or posedge RES) begin
    if (RES) begin
      state_q <= IDLE;
      hold_q <= DATA_RST;
      cnt_q <= '0;
      nack_q <= NACK_RST;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      nack_q <= nack_d;
      ovr_q <= ovr_d;
    end
  end
  par_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(E),
    .rst(RES),
    .wr(wr_en),
    .din(hold_q),
    .rd(RD),
    .dout(RD_DATA),
    .empty(EMPTY),
    .full(FULL)
  );
  assign BUSY = state_q != IDLE;
  assign nACK = nack_q;
  assign OVR = ovr_q;
`ifdef PAR_RX_IRQ_EN
  logic irq_n_q, irq_n_d;
  // Registered level interrupt from data-available or overrun
  always_comb irq_n_d = ~(IE & (~EMPTY | ovr_q));
  // Interrupt register
  always_ff @(posedge E or posedge RES) begin
    if (RES) irq_n_q <= IRQ_RST;
    else irq_n_q <= irq_n_d;
  end
  assign nIRQ = irq_n_q;
`else
  logic unused_ie;
  assign unused_ie = IE;
  assign nIRQ = IRQ_RST;
`endif
endmodule

// File: tb/tb_par_port_rx.sv
// tb_par_port_rx: scoreboard bench for par_port_rx handshake, FIFO order, overrun, reset and IRQ
module tb_par_port_rx;
  localparam int DEPTH = 4;
  localparam int ACK_CYCLES = 3;
  logic E = 1'b0, RES = 1'b1, nSTB = 1'b1, RD = 1'b0, CLR_OVR = 1'b0, IE = 1'b1;
  logic [7:0] PD = 8'h00;
  logic BUSY, nACK, EMPTY, FULL, OVR, nIRQ;
  logic [7:0] RD_DATA;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  par_port_rx #(.DEPTH(DEPTH), .ACK_CYCLES(ACK_CYCLES)) dut (
    .E(E), .RES(RES), .nSTB(nSTB), .PD(PD), .BUSY(BUSY), .nACK(nACK), .RD(RD),
    .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL), .OVR(OVR), .CLR_OVR(CLR_OVR),
    .IE(IE), .nIRQ(nIRQ)
  );
  always #5 E = ~E;
  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  task chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task cyc();
    @(negedge E);
  endtask
  task send(input logic [7:0] b);
    PD = b;
    nSTB = 1'b0;
    repeat (3) cyc();
    nSTB = 1'b1;
  endtask
  task wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, "_idle"}, int'(n < 50), 1);
  endtask
  task pop(input string tag);
    logic [7:0] e;
    chk({tag, "_ne"}, EMPTY, 0);
    if (q.size() == 0) chk({tag, "_sb"}, 0, 1);
    else begin
      e = q.pop_front();
      chk(tag, RD_DATA, e);
    end
    RD = 1'b1;
    cyc();
    RD = 1'b0;
  endtask
  task count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (!nACK) lows++;
    end
  endtask
  task overrun_seq(input logic [7:0] first, input logic clr);
    PD = first;
    nSTB = 1'b0;
    cyc();
    nSTB = 1'b1;
    cyc();
    cyc();
    PD = 8'h77;
    nSTB = 1'b0;
    cyc();
    cyc();
    nSTB = 1'b1;
    CLR_OVR = clr;
    cyc();
    CLR_OVR = 1'b0;
    q.push_back(first);
  endtask
  initial begin
    int lows;
    logic irq_exp;
`ifdef PAR_RX_IRQ_EN
    irq_exp = 1'b0;
`else
    irq_exp = 1'b1;
`endif
    cyc();
    cyc();
    RES = 1'b0;
    cyc();
    chk("rst_busy", BUSY, 0);
    chk("rst_nack", nACK, 1);
    chk("rst_data", RD_DATA, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_ovr", OVR, 0);
    chk("rst_nirq", nIRQ, 1);
    PD = 8'hA5;
    nSTB = 1'b0;
    cyc();
    chk("t1_busy_e1", BUSY, 0);
    cyc();
    chk("t1_busy_e2", BUSY, 0);
    cyc();
    chk("t1_busy_e3", BUSY, 1);
    cyc();
    chk("t1_nack_e4", nACK, 1);
    chk("t1_empty", EMPTY, 0);
    q.push_back(8'hA5);
    count_lows(6, lows);
    chk("t1_ack_len", lows, ACK_CYCLES);
    nSTB = 1'b1;
    wait_idle("t1");
    pop("t1_pop");
    chk("t1_empty_after", EMPTY, 1);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      q.push_back(8'(i));
      wait_idle("t2_fill");
    end
    chk("t2_full", FULL, 1);
    send(8'h05);
    repeat (6) cyc();
    chk("t2_hold_busy", BUSY, 1);
    chk("t2_hold_nack", nACK, 1);
    pop("t2_pop");
    q.push_back(8'h05);
    chk("t2_full_kept", FULL, 1);
    count_lows(8, lows);
    chk("t2_ack_len", lows, ACK_CYCLES);
    wait_idle("t2");
    send(8'h66);
    repeat (4) cyc();
    chk("t4_hold_busy", BUSY, 1);
    pop("t4_pop");
    q.push_back(8'h66);
    chk("t4_full_kept", FULL, 1);
    wait_idle("t4");
    repeat (4) pop("t4_drain");
    chk("t4_empty", EMPTY, 1);
    RD = 1'b1;
    cyc();
    RD = 1'b0;
    chk("t4_rd_empty", EMPTY, 1);
    chk("t4_rd_full", FULL, 0);
    overrun_seq(8'h10, 1'b0);
    chk("t3_ovr_set", OVR, 1);
    wait_idle("t3a");
    CLR_OVR = 1'b1;
    cyc();
    CLR_OVR = 1'b0;
    chk("t3_ovr_clr", OVR, 0);
    overrun_seq(8'h11, 1'b1);
    chk("t3_set_wins", OVR, 1);
    wait_idle("t3b");
    pop("t3_pop");
    pop("t3_pop");
    chk("t3_count", EMPTY, 1);
    CLR_OVR = 1'b1;
    cyc();
    CLR_OVR = 1'b0;
    chk("t3_ovr_clr2", OVR, 0);
    PD = 8'hC3;
    nSTB = 1'b0;
    repeat (6) cyc();
    chk("t5_ack_low", nACK, 0);
    chk("t5_ne", EMPTY, 0);
    RES = 1'b1;
    #1;
    chk("t5_nack_rel", nACK, 1);
    chk("t5_flush", EMPTY, 1);
    chk("t5_busy", BUSY, 0);
    q.delete();
    cyc();
    RES = 1'b0;
    repeat (6) cyc();
    chk("t5_no_cap_busy", BUSY, 0);
    chk("t5_no_cap_empty", EMPTY, 1);
    nSTB = 1'b1;
    repeat (3) cyc();
    chk("t5_rise_busy", BUSY, 0);
    send(8'h3C);
    q.push_back(8'h3C);
    wait_idle("t5");
    pop("t5_pop");
    send(8'h5A);
    cyc();
    chk("t6_empty", EMPTY, 0);
    chk("t6_nirq_pre", nIRQ, 1);
    cyc();
    chk("t6_nirq", nIRQ, int'(irq_exp));
    q.push_back(8'h5A);
    wait_idle("t6");
    pop("t6_pop");
    chk("t6_drained", EMPTY, 1);
    chk("t6_nirq_lag", nIRQ, int'(irq_exp));
    cyc();
    chk("t6_nirq_rel", nIRQ, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
